// File: rtl/cmos_pixel_packer_if.sv
// Camera-side and pixel-side signal bundle for cmos_pixel_packer.
//   vsync_i, href_i, pdata_i : camera sync, line-valid and data beat (driven by master)
//   pdata_o, de_o, sof_o     : assembled pixel, valid strobe, start-of-frame flag
//   eol_o, line_err_o        : end-of-line pulse, incomplete-pixel-at-end-of-line pulse
//   x_o, y_o                 : pixel / line index of pdata_o
// IN_W and RATIO must match the parameters of the attached packer.
interface cmos_pixel_packer_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned RATIO = 2
);
  logic                  vsync_i;
  logic                  href_i;
  logic [IN_W-1:0]       pdata_i;
  logic [IN_W*RATIO-1:0] pdata_o;
  logic                  de_o;
  logic                  sof_o;
  logic                  eol_o;
  logic [11:0]           x_o;
  logic [11:0]           y_o;
  logic                  line_err_o;

  modport master (
    output vsync_i, href_i, pdata_i,
    input  pdata_o, de_o, sof_o, eol_o, x_o, y_o, line_err_o
  );

  modport slave (
    input  vsync_i, href_i, pdata_i,
    output pdata_o, de_o, sof_o, eol_o, x_o, y_o, line_err_o
  );
endinterface

// File: rtl/cmos_pixel_packer.sv
// Packs RATIO camera beats of IN_W bits into one pixel with frame/line position tags.
// Ports:
//   pclk : camera pixel clock, rising edge
//   rst  : asynchronous active-high reset
//   cam  : cmos_pixel_packer_if slave modport (camera inputs, registered pixel outputs)
// Nothing is emitted until a vertical blanking period (vsync_i == VS_POL) has been seen,
// so the first frame after reset is never emitted partially.
module cmos_pixel_packer #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned RATIO     = 2,
  parameter int unsigned BYTE_SWAP = 0,
  parameter bit          VS_POL    = 1'b1
) (
  input  logic                pclk,
  input  logic                rst,
  cmos_pixel_packer_if.slave  cam
);

  localparam int unsigned PW = IN_W * RATIO;

  typedef enum logic [0:0] {StWaitSync, StActive} state_e;

  state_e         state_q;
  logic [1:0]     beat_q;
  logic [PW-1:0]  shift_q;
  logic           href_q;
  logic           sof_arm_q;
  logic [11:0]    x_q;
  logic [11:0]    y_q;

  logic           vblank;
  logic           last_beat;
  logic [PW-1:0]  beat_ext;
  logic [PW-1:0]  shift_d;

  assign vblank    = (cam.vsync_i == VS_POL);
  assign last_beat = (beat_q == 2'(RATIO - 1));
  assign beat_ext  = PW'(cam.pdata_i);

  // First beat ends up in the MSBs (left shift) or in the LSBs (right shift, enter at top).
  always_comb begin
    shift_d = '0;
    if (BYTE_SWAP != 0) begin
      shift_d = (shift_q >> IN_W) | (beat_ext << (PW - IN_W));
    end else begin
      shift_d = (shift_q << IN_W) | beat_ext;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q        <= StWaitSync;
      beat_q         <= '0;
      shift_q        <= '0;
      href_q         <= 1'b0;
      sof_arm_q      <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      cam.pdata_o    <= '0;
      cam.de_o       <= 1'b0;
      cam.sof_o      <= 1'b0;
      cam.eol_o      <= 1'b0;
      cam.line_err_o <= 1'b0;
      cam.x_o        <= '0;
      cam.y_o        <= '0;
    end else begin
      // Outputs are single-cycle pulses; data and indices read zero outside de_o.
      cam.pdata_o    <= '0;
      cam.de_o       <= 1'b0;
      cam.sof_o      <= 1'b0;
      cam.eol_o      <= 1'b0;
      cam.line_err_o <= 1'b0;
      cam.x_o        <= '0;
      cam.y_o        <= '0;

      if (vblank) begin
        // Blanking (from either state): drop any partial pixel silently, restart the frame.
        state_q   <= StActive;
        beat_q    <= '0;
        shift_q   <= '0;
        href_q    <= 1'b0;
        x_q       <= '0;
        y_q       <= '0;
        sof_arm_q <= 1'b1;
      end else if (state_q == StActive) begin
        href_q <= cam.href_i;
        if (cam.href_i) begin
          shift_q <= shift_d;
          if (last_beat) begin
            beat_q      <= '0;
            cam.de_o    <= 1'b1;
            cam.pdata_o <= shift_d;
            cam.sof_o   <= sof_arm_q;
            cam.x_o     <= x_q;
            cam.y_o     <= y_q;
            sof_arm_q   <= 1'b0;
            if (x_q != 12'hFFF) x_q <= x_q + 12'd1;
          end else begin
            beat_q <= beat_q + 2'd1;
          end
        end else begin
          beat_q  <= '0;
          shift_q <= '0;
          if (href_q) begin
            cam.eol_o      <= 1'b1;
            cam.line_err_o <= (beat_q != 2'd0);
            x_q            <= '0;
            if (y_q != 12'hFFF) y_q <= y_q + 12'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Directed bench: three packers (defaults, BYTE_SWAP=1, RATIO=3) share one camera stream.
module tb_cmos_pixel_packer;

  logic       pclk;
  logic       rst;
  logic       vsync;
  logic       href;
  logic [7:0] pdata;

  int tests_run    = 0;
  int tests_failed = 0;

  cmos_pixel_packer_if #(.IN_W(8), .RATIO(2)) if0 ();
  cmos_pixel_packer_if #(.IN_W(8), .RATIO(2)) if1 ();
  cmos_pixel_packer_if #(.IN_W(8), .RATIO(3)) if2 ();

  assign if0.vsync_i = vsync;
  assign if0.href_i  = href;
  assign if0.pdata_i = pdata;
  assign if1.vsync_i = vsync;
  assign if1.href_i  = href;
  assign if1.pdata_i = pdata;
  assign if2.vsync_i = vsync;
  assign if2.href_i  = href;
  assign if2.pdata_i = pdata;

  cmos_pixel_packer #(.IN_W(8), .RATIO(2), .BYTE_SWAP(0), .VS_POL(1'b1)) u0 (
    .pclk (pclk),
    .rst  (rst),
    .cam  (if0.slave)
  );

  cmos_pixel_packer #(.IN_W(8), .RATIO(2), .BYTE_SWAP(1), .VS_POL(1'b1)) u1 (
    .pclk (pclk),
    .rst  (rst),
    .cam  (if1.slave)
  );

  cmos_pixel_packer #(.IN_W(8), .RATIO(3), .BYTE_SWAP(0), .VS_POL(1'b1)) u2 (
    .pclk (pclk),
    .rst  (rst),
    .cam  (if2.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    vsync = 1'b0;
    href  = 1'b0;
    pdata = 8'h00;
    tick();
    tick();

    // Reset state
    chk("rst_de",    32'(if0.de_o),       32'h0);
    chk("rst_pdata", 32'(if0.pdata_o),    32'h0);
    chk("rst_sof",   32'(if0.sof_o),      32'h0);
    chk("rst_eol",   32'(if0.eol_o),      32'h0);
    chk("rst_err",   32'(if0.line_err_o), 32'h0);
    chk("rst_x",     32'(if0.x_o),        32'h0);
    chk("rst_y",     32'(if0.y_o),        32'h0);
    chk("rst_de_u2", 32'(if2.de_o),       32'h0);
    rst = 1'b0;

    // Line activity before any vsync blanking is ignored
    href = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pdata = 8'hA0 + 8'(i);
      tick();
      chk("nosync_de_u0", 32'(if0.de_o), 32'h0);
      chk("nosync_de_u2", 32'(if2.de_o), 32'h0);
    end
    href = 1'b0;
    tick();
    chk("nosync_eol", 32'(if0.eol_o), 32'h0);

    // Blanking arms the frame
    vsync = 1'b1;
    tick();
    tick();
    chk("blank_de", 32'(if0.de_o), 32'h0);
    vsync = 1'b0;
    tick();

    // Line 0: 12 34 56 78
    href  = 1'b1;
    pdata = 8'h12;
    tick();
    chk("l0b0_de", 32'(if0.de_o), 32'h0);
    pdata = 8'h34;
    tick();
    chk("l0p0_de",    32'(if0.de_o),    32'h1);
    chk("l0p0_data",  32'(if0.pdata_o), 32'h1234);
    chk("l0p0_x",     32'(if0.x_o),     32'h0);
    chk("l0p0_y",     32'(if0.y_o),     32'h0);
    chk("l0p0_sof",   32'(if0.sof_o),   32'h1);
    chk("l0p0_swap",  32'(if1.pdata_o), 32'h3412);
    chk("l0p0_u2_de", 32'(if2.de_o),    32'h0);
    pdata = 8'h56;
    tick();
    chk("l0b2_de",     32'(if0.de_o),    32'h0);
    chk("l0_u2_de",    32'(if2.de_o),    32'h1);
    chk("l0_u2_data",  32'(if2.pdata_o), 32'h123456);
    chk("l0_u2_sof",   32'(if2.sof_o),   32'h1);
    pdata = 8'h78;
    tick();
    chk("l0p1_de",    32'(if0.de_o),    32'h1);
    chk("l0p1_data",  32'(if0.pdata_o), 32'h5678);
    chk("l0p1_x",     32'(if0.x_o),     32'h1);
    chk("l0p1_sof",   32'(if0.sof_o),   32'h0);
    chk("l0p1_swap",  32'(if1.pdata_o), 32'h7856);
    chk("l0p1_eol",   32'(if0.eol_o),   32'h0);
    href = 1'b0;
    tick();
    chk("l0_eol",     32'(if0.eol_o),      32'h1);
    chk("l0_err",     32'(if0.line_err_o), 32'h0);
    chk("l0_de_off",  32'(if0.de_o),       32'h0);
    chk("l0_pd_off",  32'(if0.pdata_o),    32'h0);
    chk("l0_u2_eol",  32'(if2.eol_o),      32'h1);
    chk("l0_u2_err",  32'(if2.line_err_o), 32'h1);
    tick();
    chk("l0_eol_pulse", 32'(if0.eol_o), 32'h0);

    // Line 1: 9A BC
    href  = 1'b1;
    pdata = 8'h9A;
    tick();
    pdata = 8'hBC;
    tick();
    chk("l1_data", 32'(if0.pdata_o), 32'h9ABC);
    chk("l1_swap", 32'(if1.pdata_o), 32'hBC9A);
    chk("l1_x",    32'(if0.x_o),     32'h0);
    chk("l1_y",    32'(if0.y_o),     32'h1);
    chk("l1_sof",  32'(if0.sof_o),   32'h0);
    href = 1'b0;
    tick();
    chk("l1_eol", 32'(if0.eol_o), 32'h1);
    tick();

    // Line 2: seven beats 01..07
    href = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      pdata = 8'(i);
      tick();
      chk("l2_u0_de", 32'(if0.de_o), ((i % 2) == 0) ? 32'h1 : 32'h0);
      chk("l2_u2_de", 32'(if2.de_o), ((i % 3) == 0) ? 32'h1 : 32'h0);
      if ((i % 2) == 0) begin
        chk("l2_u0_data", 32'(if0.pdata_o), 32'(((i - 1) << 8) | i));
        chk("l2_u0_x",    32'(if0.x_o),     32'((i / 2) - 1));
        chk("l2_u0_y",    32'(if0.y_o),     32'h2);
      end
      if ((i % 3) == 0) begin
        chk("l2_u2_data", 32'(if2.pdata_o), 32'(((i - 2) << 16) | ((i - 1) << 8) | i));
        chk("l2_u2_x",    32'(if2.x_o),     32'((i / 3) - 1));
        chk("l2_u2_y",    32'(if2.y_o),     32'h2);
      end
    end
    href = 1'b0;
    tick();
    chk("l2_u2_eol", 32'(if2.eol_o),      32'h1);
    chk("l2_u2_err", 32'(if2.line_err_o), 32'h1);
    chk("l2_u2_de",  32'(if2.de_o),       32'h0);
    chk("l2_u0_err", 32'(if0.line_err_o), 32'h1);
    tick();

    // Blanking with href high: beats ignored, no eol
    vsync = 1'b1;
    href  = 1'b1;
    pdata = 8'hEE;
    tick();
    tick();
    chk("vbh_de",  32'(if0.de_o),  32'h0);
    chk("vbh_eol", 32'(if0.eol_o), 32'h0);
    vsync = 1'b0;
    href  = 1'b0;
    tick();
    chk("vbh_eol2", 32'(if0.eol_o), 32'h0);

    // First line of new frame: y back to 0, sof set
    href  = 1'b1;
    pdata = 8'hDE;
    tick();
    pdata = 8'hAD;
    tick();
    chk("f2_data", 32'(if0.pdata_o), 32'hDEAD);
    chk("f2_y",    32'(if0.y_o),     32'h0);
    chk("f2_x",    32'(if0.x_o),     32'h0);
    chk("f2_sof",  32'(if0.sof_o),   32'h1);
    href = 1'b0;
    tick();
    tick();

    // Blanking mid-pixel drops the partial beat without line_err
    href  = 1'b1;
    pdata = 8'h11;
    tick();
    vsync = 1'b1;
    tick();
    chk("vbp_de",  32'(if0.de_o),       32'h0);
    chk("vbp_eol", 32'(if0.eol_o),      32'h0);
    chk("vbp_err", 32'(if0.line_err_o), 32'h0);
    vsync = 1'b0;
    href  = 1'b0;
    tick();
    chk("vbp_eol2", 32'(if0.eol_o), 32'h0);
    href  = 1'b1;
    pdata = 8'h22;
    tick();
    chk("vbp_b0_de", 32'(if0.de_o), 32'h0);
    pdata = 8'h33;
    tick();
    chk("vbp_data", 32'(if0.pdata_o), 32'h2233);
    chk("vbp_sof",  32'(if0.sof_o),   32'h1);
    href = 1'b0;
    tick();

    // Reset asserted while a pixel is on the outputs, mid-frame
    href  = 1'b1;
    pdata = 8'h44;
    tick();
    pdata = 8'h55;
    tick();
    chk("pre_rst_data", 32'(if0.pdata_o), 32'h4455);
    chk("pre_rst_y",    32'(if0.y_o),     32'h1);
    rst = 1'b1;
    #1;
    chk("arst_de",    32'(if0.de_o),    32'h0);
    chk("arst_pdata", 32'(if0.pdata_o), 32'h0);
    chk("arst_y",     32'(if0.y_o),     32'h0);
    chk("arst_u1_de", 32'(if1.de_o),    32'h0);
    rst   = 1'b0;
    pdata = 8'h66;
    tick();
    pdata = 8'h77;
    tick();
    chk("post_rst_de", 32'(if0.de_o), 32'h0);
    href = 1'b0;
    tick();
    chk("post_rst_eol", 32'(if0.eol_o), 32'h0);

    // Recovery after a fresh blanking period
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    href  = 1'b1;
    pdata = 8'h88;
    tick();
    pdata = 8'h99;
    tick();
    chk("rec_data", 32'(if0.pdata_o), 32'h8899);
    chk("rec_swap", 32'(if1.pdata_o), 32'h9988);
    chk("rec_sof",  32'(if0.sof_o),   32'h1);
    href = 1'b0;
    tick();
    chk("rec_eol", 32'(if0.eol_o), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
